// File: rtl/freq_sample_writer.sv
// Write side of the frequency meter's measurement memory: counts synchronized
// rising edges of sig_in over a fixed gate window and writes each count to a 4-slot ring.
module freq_sample_writer #(
  parameter int unsigned N           = 26,
  parameter int unsigned GATE_CYCLES = 100000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sig_in,
  input  logic         enable,
  output logic [1:0]   addr_w,
  output logic [N-1:0] data_w,
  output logic         we,
  output logic         filled,
  output logic         gate_active
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [N-1:0]  EDGE_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic           s1, s2, s3;
  logic           rise;
  logic [GW-1:0]  gate_cnt, gate_cnt_next;
  logic [N-1:0]   edge_cnt, edge_cnt_next, edge_inc;

  // Three-flop synchronizer; the third stage only serves edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Saturating edge count including this cycle's rise
  always_comb begin
    edge_inc = edge_cnt;
    if (rise && (edge_cnt != EDGE_MAX)) begin
      edge_inc = edge_cnt + N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and counter updates; counters default to clear outside GATE
  always_comb begin
    state_next    = state;
    gate_cnt_next = '0;
    edge_cnt_next = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = GATE;
        end
      end
      GATE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          state_next = WRITE;
        end else begin
          gate_cnt_next = gate_cnt + GW'(1);
          edge_cnt_next = edge_inc;
        end
      end
      WRITE: begin
        state_next = enable ? GATE : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs, loaded from the next-state decode so they align with state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      addr_w      <= 2'd0;
      data_w      <= '0;
      we          <= 1'b0;
      filled      <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      gate_cnt    <= gate_cnt_next;
      edge_cnt    <= edge_cnt_next;
      we          <= (state_next == WRITE);
      gate_active <= (state_next == GATE);
      if ((state == GATE) && (state_next == WRITE)) begin
        data_w <= edge_inc;
      end
      if (state == WRITE) begin
        addr_w <= addr_w + 2'd1;
        if (addr_w == 2'd3) begin
          filled <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_sample_writer.sv
// Directed bench for freq_sample_writer: a vector table of signal patterns plus
// hand-built sequences for aborts, reset mid-gate, saturation and last-cycle edges.
module tb_freq_sample_writer;

  localparam int unsigned NA = 26;
  localparam int unsigned GA = 16;
  localparam int unsigned NB = 3;
  localparam int unsigned GB = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sig_a, sig_b, en_a, en_b;
  logic [1:0]    addr_a, addr_b;
  logic [NA-1:0] data_a;
  logic [NB-1:0] data_b;
  logic          we_a, we_b, filled_a, filled_b, ga_a, ga_b;

  freq_sample_writer #(.N(NA), .GATE_CYCLES(GA)) dut_a (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_a), .enable(en_a),
    .addr_w(addr_a), .data_w(data_a), .we(we_a), .filled(filled_a), .gate_active(ga_a)
  );

  freq_sample_writer #(.N(NB), .GATE_CYCLES(GB)) dut_b (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_b), .enable(en_b),
    .addr_w(addr_b), .data_w(data_b), .we(we_b), .filled(filled_b), .gate_active(ga_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;    // 0 = constant level
    bit level;
    int nwrites;
    int exp_data;
  } vec_t;

  vec_t vecs[5];
  int   vecs_applied = 0;
  int   miscompares  = 0;
  int   cyc_n        = 0;
  int   per_a = 0, per_b = 0;
  bit   lvl_a = 1'b0, lvl_b = 1'b0;
  int   lat;

  task automatic chk(input string name, input longint act, input longint exp);
    vecs_applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_sig();
    sig_a = (per_a == 0) ? lvl_a : ((cyc_n % per_a) < (per_a / 2));
    sig_b = (per_b == 0) ? lvl_b : ((cyc_n % per_b) < (per_b / 2));
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    drive_sig();
  endtask

  task automatic do_reset();
    en_a    = 1'b0;
    en_b    = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
  endtask

  // Cycles until the selected we is seen, or -1 if the budget runs out
  task automatic wait_we(input bit sel_b, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if ((sel_b ? we_b : we_a) == 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{4, 1'b0, 5, 4};
    vecs[1] = '{0, 1'b0, 4, 0};
    vecs[2] = '{0, 1'b1, 4, 0};
    vecs[3] = '{2, 1'b0, 4, 8};
    vecs[4] = '{8, 1'b0, 4, 2};

    reset_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    sig_a = 1'b0; sig_b = 1'b0;

    for (int v = 0; v < 5; v++) begin
      per_a = vecs[v].period;
      lvl_a = vecs[v].level;
      do_reset();
      chk("rst_addr", addr_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_we", we_a, 0);
      chk("rst_filled", filled_a, 0);
      chk("rst_gate", ga_a, 0);
      repeat (10) cyc();
      chk("idle_gate", ga_a, 0);
      chk("idle_addr", addr_a, 0);
      en_a = 1'b1;
      cyc();
      chk("gate_latency", ga_a, 1);
      for (int w = 0; w < vecs[v].nwrites; w++) begin
        wait_we(1'b0, 40, lat);
        chk("we_spacing", lat, (w == 0) ? GA : GA + 1);
        chk("data", data_a, vecs[v].exp_data);
        chk("addr", addr_a, w % 4);
        chk("filled_at_we", filled_a, (w >= 4) ? 1 : 0);
      end
      cyc();
      chk("filled_after", filled_a, (vecs[v].nwrites >= 4) ? 1 : 0);
      chk("addr_after", addr_a, vecs[v].nwrites % 4);
      en_a = 1'b0;
    end

    // Saturation on the narrow instance
    do_reset();
    per_b = 2;
    repeat (5) cyc();
    en_b = 1'b1;
    cyc();
    chk("b_gate", ga_b, 1);
    wait_we(1'b1, 70, lat);
    chk("b_lat0", lat, GB);
    chk("b_sat0", data_b, 7);
    wait_we(1'b1, 70, lat);
    chk("b_lat1", lat, GB + 1);
    chk("b_sat1", data_b, 7);
    cyc();
    chk("b_addr", addr_b, 2);
    chk("b_filled", filled_b, 0);
    en_b = 1'b0;

    // Rise in last gate cycle is counted; one cycle later falls in WRITE dead time
    for (int a = 14; a <= 15; a++) begin
      per_a = 0;
      lvl_a = 1'b0;
      do_reset();
      repeat (5) cyc();
      en_a = 1'b1;
      repeat (a) cyc();
      lvl_a = 1'b1;
      sig_a = 1'b1;
      wait_we(1'b0, 30, lat);
      chk("edge_lat", lat, 17 - a);
      chk("edge_last_cycle", data_a, (a == 14) ? 1 : 0);
      en_a = 1'b0;
    end

    // Enable dropped on the last gate cycle aborts the write
    per_a = 4;
    do_reset();
    repeat (8) cyc();
    en_a = 1'b1;
    repeat (16) cyc();
    chk("last_gate_active", ga_a, 1);
    en_a = 1'b0;
    cyc();
    chk("abort_we", we_a, 0);
    chk("abort_gate", ga_a, 0);
    chk("abort_addr", addr_a, 0);
    wait_we(1'b0, 20, lat);
    chk("abort_nowrite", lat, -1);

    // Mid-gate abort then re-enable writes the same slot
    do_reset();
    repeat (8) cyc();
    en_a = 1'b1;
    wait_we(1'b0, 40, lat);
    chk("mid_lat0", lat, 17);
    chk("mid_addr0", addr_a, 0);
    repeat (9) cyc();
    en_a = 1'b0;
    cyc();
    chk("mid_gate_off", ga_a, 0);
    chk("mid_addr_hold", addr_a, 1);
    wait_we(1'b0, 5, lat);
    chk("mid_nowrite", lat, -1);
    en_a = 1'b1;
    wait_we(1'b0, 40, lat);
    chk("mid_lat1", lat, 17);
    chk("mid_addr1", addr_a, 1);
    chk("mid_data1", data_a, 4);
    en_a = 1'b0;

    // Reset inside a gate after the ring has filled
    do_reset();
    repeat (8) cyc();
    en_a = 1'b1;
    repeat (5) wait_we(1'b0, 40, lat);
    cyc();
    chk("pre_rst_filled", filled_a, 1);
    chk("pre_rst_addr", addr_a, 1);
    repeat (5) cyc();
    reset_n = 1'b0;
    cyc();
    chk("mrst_addr", addr_a, 0);
    chk("mrst_data", data_a, 0);
    chk("mrst_we", we_a, 0);
    chk("mrst_filled", filled_a, 0);
    chk("mrst_gate", ga_a, 0);
    reset_n = 1'b1;
    wait_we(1'b0, 40, lat);
    chk("post_rst_lat", lat, 17);
    chk("post_rst_addr", addr_a, 0);
    chk("post_rst_data", data_a, 4);
    en_a = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
